// File: rtl/clk_monitor_pkg.sv
// Shared types for the clock monitor: FSM states, default counter width and verdict flags.
// The fail_duty flag exists only when CLK_MONITOR_DUTY_EN is defined.
package clk_monitor_pkg;

   localparam int CLK_MON_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } clk_mon_state_e;

   typedef struct packed {
`ifdef CLK_MONITOR_DUTY_EN
      logic fail_duty;
`endif
      logic timeout;
      logic fail_lo;
      logic fail_hi;
   } clk_mon_flags_t;

   function automatic logic flags_any(input clk_mon_flags_t f);
      return |f;
   endfunction

endpackage

// File: rtl/clk_monitor_sync_edge.sv
// sync_edge_det: N-stage synchronizer plus registered edge detector for an asynchronous input.
// The fall output is present only when CLK_MONITOR_DUTY_EN is defined.
module sync_edge_det #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
`ifdef CLK_MONITOR_DUTY_EN
   output logic fall_o,
`endif
   output logic rise_o
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;
   logic              rise_q, rise_d;
`ifdef CLK_MONITOR_DUTY_EN
   logic              fall_q, fall_d;
`endif

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], sig_i};
      prev_d = sync_q[STAGES-1];
      rise_d = sync_q[STAGES-1] & ~prev_q;
`ifdef CLK_MONITOR_DUTY_EN
      fall_d = ~sync_q[STAGES-1] & prev_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
`ifdef CLK_MONITOR_DUTY_EN
         fall_q <= 1'b0;
`endif
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
`ifdef CLK_MONITOR_DUTY_EN
         fall_q <= fall_d;
`endif
      end
   end

   assign rise_o = rise_q;
`ifdef CLK_MONITOR_DUTY_EN
   assign fall_o = fall_q;
`endif

endmodule

// File: rtl/clk_monitor.sv
// Period checker for a divided clock: counts clk cycles between synchronized mon_clk rising edges.
// Optional duty-cycle check is compiled in with CLK_MONITOR_DUTY_EN.
module clk_monitor
   import clk_monitor_pkg::*;
#(
   parameter int CNT_W       = CLK_MON_CNT_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mon_clk,
   input  logic             start,
   input  logic [CNT_W-1:0] exp_period,
   input  logic [7:0]       tol,
   input  logic [7:0]       num_periods,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail_hi,
   output logic             fail_lo,
   output logic             timeout,
`ifdef CLK_MONITOR_DUTY_EN
   output logic             fail_duty,
`endif
   output logic [CNT_W-1:0] meas_min,
   output logic [CNT_W-1:0] meas_max
);

   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int HW     = CNT_W + 1;
   localparam int WD_W   = CNT_W + 3;

   clk_mon_state_e   state_q, state_d;
   logic [CNT_W-1:0] exp_q, exp_d;
   logic [7:0]       tol_q, tol_d;
   logic [7:0]       num_q, num_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       per_q, per_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   clk_mon_flags_t   flags_q, flags_d;
   logic [CNT_W-1:0] min_q, min_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic             pass_q, pass_d;

   logic             rise;
   logic [HW-1:0]    hi, cnt_p1;
   logic [CNT_W-1:0] lo, tol_ext, period, cnt_inc;
   logic [WD_W-1:0]  wd_limit;
   logic [7:0]       per_inc;

`ifdef CLK_MONITOR_DUTY_EN
   localparam int DW = CNT_W + 2;
   logic             fall;
   logic [CNT_W-1:0] high_q, high_d;
   logic             high_vld_q, high_vld_d;
   logic [DW-1:0]    two_high, period_w, duty_err;
   logic             duty_bad;
`endif

   sync_edge_det #(
      .STAGES (STAGES)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (mon_clk),
`ifdef CLK_MONITOR_DUTY_EN
      .fall_o (fall),
`endif
      .rise_o (rise)
   );

   // hi carries one extra bit so exp_period + tol never wraps; lo clamps at zero.
   assign tol_ext  = CNT_W'(tol_q);
   assign hi       = HW'(exp_q) + HW'(tol_q);
   assign lo       = (exp_q >= tol_ext) ? exp_q - tol_ext : '0;
   assign cnt_p1   = HW'(cnt_q) + HW'(1);
   assign period   = cnt_p1[CNT_W] ? '1 : cnt_p1[CNT_W-1:0];
   assign cnt_inc  = cnt_p1[CNT_W] ? cnt_q : cnt_p1[CNT_W-1:0];
   assign wd_limit = WD_W'({hi, 1'b0}) + WD_W'(STAGES + 2);
   assign per_inc  = per_q + 8'd1;

`ifdef CLK_MONITOR_DUTY_EN
   assign two_high = {1'b0, high_q, 1'b0};
   assign period_w = DW'(period);
   assign duty_err = (two_high >= period_w) ? two_high - period_w : period_w - two_high;
   assign duty_bad = high_vld_q && (duty_err > DW'(tol_q));
`endif

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      tol_d   = tol_q;
      num_d   = num_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      wd_d    = wd_q;
      flags_d = flags_q;
      min_d   = min_q;
      max_d   = max_q;
      pass_d  = pass_q;
`ifdef CLK_MONITOR_DUTY_EN
      high_d     = high_q;
      high_vld_d = high_vld_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               exp_d   = exp_period;
               tol_d   = tol;
               num_d   = (num_periods == 8'd0) ? 8'd1 : num_periods;
               cnt_d   = '0;
               per_d   = '0;
               wd_d    = '0;
               flags_d = '0;
               min_d   = '1;
               max_d   = '0;
               pass_d  = 1'b0;
`ifdef CLK_MONITOR_DUTY_EN
               high_vld_d = 1'b0;
`endif
               state_d = ARM;
            end
         end
         ARM: begin
            // wd_q counts ARM cycles already spent; this cycle pushes the count past the limit.
            if (wd_q >= wd_limit) begin
               flags_d.timeout = 1'b1;
               pass_d          = 1'b0;
               state_d         = DONE;
            end else if (rise) begin
               cnt_d   = '0;
`ifdef CLK_MONITOR_DUTY_EN
               high_vld_d = 1'b0;
`endif
               state_d = MEASURE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         MEASURE: begin
            // Abort wins over a coincident rise: that period is already known to be too long.
            if (cnt_p1 > hi) begin
               flags_d.fail_hi = 1'b1;
               pass_d          = 1'b0;
               state_d         = DONE;
            end else if (rise) begin
               if (period < min_q) min_d = period;
               if (period > max_q) max_d = period;
               if (period < lo) flags_d.fail_lo = 1'b1;
`ifdef CLK_MONITOR_DUTY_EN
               if (duty_bad) flags_d.fail_duty = 1'b1;
               high_vld_d = 1'b0;
`endif
               cnt_d = '0;
               per_d = per_inc;
               if (per_inc == num_q) begin
                  pass_d  = ~flags_any(flags_d);
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_inc;
`ifdef CLK_MONITOR_DUTY_EN
               // The period counter restarted on the last rise, so its value here is the high time.
               if (fall) begin
                  high_d     = period;
                  high_vld_d = 1'b1;
               end
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         exp_q   <= '0;
         tol_q   <= '0;
         num_q   <= '0;
         cnt_q   <= '0;
         per_q   <= '0;
         wd_q    <= '0;
         flags_q <= '0;
         min_q   <= '1;
         max_q   <= '0;
         pass_q  <= 1'b0;
`ifdef CLK_MONITOR_DUTY_EN
         high_q     <= '0;
         high_vld_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         tol_q   <= tol_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         wd_q    <= wd_d;
         flags_q <= flags_d;
         min_q   <= min_d;
         max_q   <= max_d;
         pass_q  <= pass_d;
`ifdef CLK_MONITOR_DUTY_EN
         high_q     <= high_d;
         high_vld_q <= high_vld_d;
`endif
      end
   end

   assign busy     = (state_q == ARM) || (state_q == MEASURE);
   assign done     = (state_q == DONE);
   assign pass     = pass_q;
   assign fail_hi  = flags_q.fail_hi;
   assign fail_lo  = flags_q.fail_lo;
   assign timeout  = flags_q.timeout;
`ifdef CLK_MONITOR_DUTY_EN
   assign fail_duty = flags_q.fail_duty;
`endif
   assign meas_min = min_q;
   assign meas_max = max_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor: a bench-side divider drives mon_clk, a small period model
// predicts each verdict into a queue, and results are popped and compared on done.
module tb_clk_monitor;

   localparam int CNT_W = 16;
   localparam int W     = 5 + 2 * CNT_W;
`ifdef CLK_MONITOR_DUTY_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             mon_clk = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] exp_period = '0;
   logic [7:0]       tol = '0;
   logic [7:0]       num_periods = '0;
   logic             busy, done, pass, fail_hi, fail_lo, timeout;
   logic [CNT_W-1:0] meas_min, meas_max;
`ifdef CLK_MONITOR_DUTY_EN
   logic             fail_duty;
`endif

   logic [W-1:0] exp_q[$];
   int           n_err = 0;
   int           n_checks = 0;
   logic         last_pass = 1'b0;
   int           bc;

   int mon_div  = 3;
   int mon_high = 1;
   int mon_ph   = 0;
   bit mon_en   = 1'b0;

   clk_monitor #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mon_clk     (mon_clk),
      .start       (start),
      .exp_period  (exp_period),
      .tol         (tol),
      .num_periods (num_periods),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .fail_hi     (fail_hi),
      .fail_lo     (fail_lo),
      .timeout     (timeout),
`ifdef CLK_MONITOR_DUTY_EN
      .fail_duty   (fail_duty),
`endif
      .meas_min    (meas_min),
      .meas_max    (meas_max)
   );

   // clock / reset
   always #5 clk = ~clk;

   // Phase-stable divided source: mon_div clk cycles per period, mon_high of them high.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            mon_clk = (mon_ph < mon_high);
            mon_ph  = (mon_ph + 1 >= mon_div) ? 0 : mon_ph + 1;
         end else begin
            mon_clk = 1'b0;
            mon_ph  = 0;
         end
      end
   end

   // Expected verdict for a steady source of period p with high time h.
   function automatic logic [W-1:0] model(input int p, input int h, input int e, input int t,
                                          input bit stopped);
      int          hi, lo, derr;
      logic        fh, fl, to, fd;
      logic [15:0] mn, mx;
      hi = e + t;
      lo = (e > t) ? e - t : 0;
      fh = 1'b0; fl = 1'b0; to = 1'b0; fd = 1'b0;
      mn = 16'hFFFF; mx = 16'h0000;
      if (stopped) begin
         to = 1'b1;
      end else if (p > hi) begin
         fh = 1'b1;
      end else begin
         mn   = p[15:0];
         mx   = p[15:0];
         fl   = (p < lo);
         derr = (2 * h > p) ? 2 * h - p : p - 2 * h;
         fd   = DUTY && (derr > t);
      end
      return {~(fh | fl | to | fd), fh, fl, to, fd, mn, mx};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},    busy,     0);
      check({tag, "_done"},    done,     0);
      check({tag, "_pass"},    pass,     0);
      check({tag, "_fail_hi"}, fail_hi,  0);
      check({tag, "_fail_lo"}, fail_lo,  0);
      check({tag, "_timeout"}, timeout,  0);
      check({tag, "_min"},     meas_min, 32'hFFFF);
      check({tag, "_max"},     meas_max, 0);
`ifdef CLK_MONITOR_DUTY_EN
      check({tag, "_fail_duty"}, fail_duty, 0);
`endif
   endtask

   task automatic set_source(input bit en, input int d, input int h);
      mon_en   = en;
      mon_div  = d;
      mon_high = h;
      repeat (8) @(negedge clk);
   endtask

   // driver: push the prediction, pulse start, check the 1-cycle busy latency
   task automatic launch(input int e, input int t, input int n);
      exp_q.push_back(model(mon_div, mon_high, e, t, !mon_en));
      @(negedge clk);
      check("done_idle", done, 0);
      check("pass_held", pass, last_pass);
      exp_period  = e[CNT_W-1:0];
      tol         = t[7:0];
      num_periods = n[7:0];
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_latency", busy, 1);
   endtask

   task automatic wait_done(input string tag, output int busy_cyc);
      logic [W-1:0] e;
      bit           seen;
      busy_cyc = 0;
      seen     = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) busy_cyc++;
      end
      check({tag, "_done_seen"}, seen, 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      last_pass = e[W-1];
      if (seen) begin
         check({tag, "_pass"},    pass,     e[W-1]);
         check({tag, "_fail_hi"}, fail_hi,  e[W-2]);
         check({tag, "_fail_lo"}, fail_lo,  e[W-3]);
         check({tag, "_timeout"}, timeout,  e[W-4]);
         check({tag, "_min"},     meas_min, e[2*CNT_W-1:CNT_W]);
         check({tag, "_max"},     meas_max, e[CNT_W-1:0]);
         check({tag, "_busy_low"}, busy,    0);
`ifdef CLK_MONITOR_DUTY_EN
         check({tag, "_fail_duty"}, fail_duty, e[W-5]);
`endif
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;

      // exact divide-by-3; a start while busy carries bad settings and must be ignored
      set_source(1'b1, 3, 1);
      launch(3, 0, 4);
      repeat (2) @(negedge clk);
      exp_period = 16'd9;
      tol        = 8'd5;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_ignored_start", busy, 1);
      wait_done("div3", bc);

      // restart in the IDLE cycle right after done; num_periods=0 behaves as 1
      launch(3, 0, 0);
      wait_done("div3_n0", bc);

      // period above hi aborts in the first period
      set_source(1'b1, 5, 2);
      launch(3, 1, 2);
      wait_done("div5_hi", bc);

      // period at exactly hi passes
      launch(4, 1, 2);
      wait_done("hi_edge", bc);

      // period below lo: flagged, all periods still measured
      set_source(1'b1, 2, 1);
      launch(4, 1, 3);
      wait_done("div2_lo", bc);

      // tol larger than exp: lo clamps to 0
      launch(2, 5, 2);
      wait_done("lo_clamp", bc);

      // period at exactly lo passes
      set_source(1'b1, 3, 1);
      launch(4, 1, 2);
      wait_done("lo_edge", bc);

      // no edges: limit 2*(3+0)+2+2 = 10, so the 11th ARM cycle times out
      set_source(1'b0, 3, 1);
      launch(3, 0, 1);
      wait_done("timeout", bc);
      check("timeout_arm_cycles", bc, 10);

`ifdef CLK_MONITOR_DUTY_EN
      set_source(1'b1, 4, 1);
      launch(4, 1, 2);
      wait_done("duty_bad", bc);
      set_source(1'b1, 4, 2);
      launch(4, 1, 2);
      wait_done("duty_ok", bc);
`endif

      // reset during MEASURE discards the run
      set_source(1'b1, 5, 2);
      launch(5, 0, 8);
      repeat (20) @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_min", meas_min, 5);
      check("mid_max", meas_max, 5);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("mid_reset");
      rst_n = 1'b1;
      exp_q.delete();
      last_pass = 1'b0;

      set_source(1'b1, 4, 2);
      launch(4, 0, 2);
      wait_done("post_reset", bc);

      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
